writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus write-back logic of the 5-stage MIPS datapath.
- Latches memory-stage results and formats load data per MuxLoad.
- Selects the write-back source per MemReg.
- Drives the register-file write port of the decode stage (WriteData, WriteRegDst, RegWrite).
- Provides a one-entry write bypass and a retired-instruction counter.

Parameters:
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous reset, active-high.
- Stall_in  in  1  hold MEM/WB register contents.
- Flush_in  in  1  load a bubble into MEM/WB.
- Valid_in  in  1  MEM-stage slot holds a real instruction.
- RegWrite_in  in  1  instruction writes a register.
- MemReg_in  in  2  source: 00 ALU result, 01 load data, 10 PC+8 (link), 11 ALU result.
- MuxLoad_in  in  2  load format: 00 word, 01 signed half, 10 signed byte, 11 unsigned half.
- ByteOffset_in  in  2  effective address [1:0].
- WriteRegDst_in  in  5  destination register number.
- ALUResult_in  in  32  ALU result from MEM stage.
- MemData_in  in  32  raw data-memory read word.
- PCPlus4_in  in  32  PC+4 of the instruction.
- WriteData_out  out  32  register-file write data.
- WriteRegDst_out  out  32  destination, zero-extended to 32 bits for the decode write port.
- RegWrite_out  out  1  register-file write enable.
- BypassValid_out  out  1  bypass entry valid.
- BypassReg_out  out  5  register written in the previous cycle.
- BypassData_out  out  32  data written in the previous cycle.
- RetireCount_out  out  RETIRE_W  retired-instruction count.

Behaviour:
- Priority on each rising edge: Rst > Flush_in > Stall_in > capture.
- Rst: every MEM/WB field cleared, including Valid and Done; all outputs 0 on the following cycle; RetireCount_out 0.
- Rst mid-operation discards the held entry with no write.
- Flush_in=1: Valid<=0, Done<=0, RegWrite<=0; other fields don't-care. Flush with Stall_in=1 still flushes.
- Stall_in=1 (no flush): all fields hold.
- Capture (Stall_in=0, Flush_in=0): all *_in fields latched; Done<=0. Latency from inputs to WriteData_out is one cycle.
- Done bit: set on the edge after any cycle where the entry is valid. Done suppresses repeated writes while stalled.
- RegWrite_out = Valid & RegWrite & !Done & (Dst != 0). Writes to $0 are never issued.
- Load formatting, little-endian byte lanes, from registered fields:
  - Byte lane k = MemData[8k+7:8k], with k = ByteOffset.
  - Halfword = MemData[15:0] if ByteOffset[1]=0, else MemData[31:16]; ByteOffset[0] ignored.
  - 01: sign-extend half. 10: sign-extend byte. 11: zero-extend half. 00: word as-is.
- Link value = PCPlus4 + 4, 32-bit wrapping add.
- WriteData_out: combinational mux of the registered fields per MemReg. Valid even when RegWrite_out=0.
- WriteRegDst_out = {27'd0, Dst}.
- Bypass register, updated every edge:
  - If RegWrite_out=1: BypassValid<=1, BypassReg<=Dst, BypassData<=WriteData_out.
  - Else BypassValid<=0; Reg and Data hold.
  - Not affected by Stall_in. Cleared by Rst.
- Retire counter: +1 on each edge where Valid=1 and Done=0 (each instruction counted once, stalled or not). Wraps modulo 2^RETIRE_W. Unaffected by Flush except that flushed slots are never counted.

Test Plan:
- Rst held 2 cycles, then released with all inputs 0 → all outputs 0; RetireCount_out=0.
- Capture Valid=1, RegWrite=1, MemReg=00, Dst=8, ALUResult=32'h0000_1234 → next cycle RegWrite_out=1, WriteData_out=32'h1234, WriteRegDst_out=8. Following cycle BypassValid_out=1, BypassReg_out=8, BypassData_out=32'h1234, RetireCount_out=1.
- Loads with MemData=32'h80FF_7F01, MemReg=01:
  - MuxLoad=10, offset 3 → WriteData_out=32'hFFFF_FF80.
  - MuxLoad=01, offset 2 → 32'hFFFF_80FF.
  - MuxLoad=11, offset 0 → 32'h0000_7F01.
  - MuxLoad=00 → 32'h80FF_7F01.
- Capture a write to Dst=5, then Stall_in=1 for 3 cycles → RegWrite_out=1 only in the first cycle, then 0. RetireCount_out increments once. BypassValid_out=1 for exactly one cycle.
- Write to Dst=0 with RegWrite_in=1 → RegWrite_out stays 0; counter still increments. Jal case: MemReg=10, PCPlus4=32'hFFFF_FFFC → WriteData_out=32'h0000_0000 (wrap).
- Flush_in and Stall_in both 1 while a valid write is held → next cycle RegWrite_out=0 and no count. Assert Rst during a stalled valid entry → no write issued afterwards; counter 0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: MEM-stage results in, register-file write port,
// bypass entry and retire count out.
interface writeback_stage_if #(
    parameter int RETIRE_W = 32
);
    logic                Stall_in;
    logic                Flush_in;
    logic                Valid_in;
    logic                RegWrite_in;
    logic [1:0]          MemReg_in;
    logic [1:0]          MuxLoad_in;
    logic [1:0]          ByteOffset_in;
    logic [4:0]          WriteRegDst_in;
    logic [31:0]         ALUResult_in;
    logic [31:0]         MemData_in;
    logic [31:0]         PCPlus4_in;

    logic [31:0]         WriteData_out;
    logic [31:0]         WriteRegDst_out;
    logic                RegWrite_out;
    logic                BypassValid_out;
    logic [4:0]          BypassReg_out;
    logic [31:0]         BypassData_out;
    logic [RETIRE_W-1:0] RetireCount_out;

    // MEM-stage side: drives the slot, observes the write-back results
    modport master (
        output Stall_in, Flush_in, Valid_in, RegWrite_in, MemReg_in, MuxLoad_in,
               ByteOffset_in, WriteRegDst_in, ALUResult_in, MemData_in, PCPlus4_in,
        input  WriteData_out, WriteRegDst_out, RegWrite_out, BypassValid_out,
               BypassReg_out, BypassData_out, RetireCount_out
    );

    // Write-back stage side
    modport slave (
        input  Stall_in, Flush_in, Valid_in, RegWrite_in, MemReg_in, MuxLoad_in,
               ByteOffset_in, WriteRegDst_in, ALUResult_in, MemData_in, PCPlus4_in,
        output WriteData_out, WriteRegDst_out, RegWrite_out, BypassValid_out,
               BypassReg_out, BypassData_out, RetireCount_out
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back logic: load formatting, source
// select, register-file write enable, one-entry write bypass, retire counter.
module writeback_stage #(
    parameter int RETIRE_W = 32
) (
    input logic             Clk,
    input logic             Rst,
    writeback_stage_if.slave wb
);

    // MEM/WB register fields
    logic                vld_p1;
    logic                done_p1;
    logic                rw_p1;
    logic [1:0]          memreg_p1;
    logic [1:0]          muxload_p1;
    logic [1:0]          off_p1;
    logic [4:0]          dst_p1;
    logic [31:0]         alu_p1;
    logic [31:0]         mem_p1;
    logic [31:0]         pc4_p1;

    logic                byp_vld_p2;
    logic [4:0]          byp_reg_p2;
    logic [31:0]         byp_data_p2;
    logic [RETIRE_W-1:0] retire_cnt;

    logic [31:0]         load_data;
    logic [31:0]         link_data;
    logic [31:0]         wr_data;
    logic                wr_en;

    // Little-endian lane extraction; halfword selection ignores offset bit 0.
    function automatic logic [31:0] fmt_load(input logic [1:0]  mux,
                                             input logic [1:0]  off,
                                             input logic [31:0] data);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = off[1] ? data[31:16] : data[15:0];
        case (mux)
            2'b00:   r = data;
            2'b01:   r = {{16{h[15]}}, h};
            2'b10:   r = {{24{b[7]}}, b};
            default: r = {16'd0, h};
        endcase
        return r;
    endfunction

    // ---- MEM -> WB boundary ----
    // MEM/WB register: reset, flush to bubble, hold on stall, else capture
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_p1     <= 1'b0;
            done_p1    <= 1'b0;
            rw_p1      <= 1'b0;
            memreg_p1  <= 2'd0;
            muxload_p1 <= 2'd0;
            off_p1     <= 2'd0;
            dst_p1     <= 5'd0;
            alu_p1     <= 32'd0;
            mem_p1     <= 32'd0;
            pc4_p1     <= 32'd0;
        end else if (wb.Flush_in) begin
            vld_p1     <= 1'b0;
            done_p1    <= 1'b0;
            rw_p1      <= 1'b0;
        end else if (wb.Stall_in) begin
            // A held entry has had its write cycle; later cycles must not repeat it.
            done_p1    <= done_p1 | vld_p1;
        end else begin
            vld_p1     <= wb.Valid_in;
            done_p1    <= 1'b0;
            rw_p1      <= wb.RegWrite_in;
            memreg_p1  <= wb.MemReg_in;
            muxload_p1 <= wb.MuxLoad_in;
            off_p1     <= wb.ByteOffset_in;
            dst_p1     <= wb.WriteRegDst_in;
            alu_p1     <= wb.ALUResult_in;
            mem_p1     <= wb.MemData_in;
            pc4_p1     <= wb.PCPlus4_in;
        end
    end

    // Write-back source select and write enable ($0 is never written)
    always_comb begin
        load_data = fmt_load(muxload_p1, off_p1, mem_p1);
        link_data = pc4_p1 + 32'd4;
        case (memreg_p1)
            2'b01:   wr_data = load_data;
            2'b10:   wr_data = link_data;
            default: wr_data = alu_p1;
        endcase
        wr_en = vld_p1 & rw_p1 & ~done_p1 & (dst_p1 != 5'd0);
    end

    // ---- WB -> bypass boundary ----
    // Bypass entry mirrors the write issued in the previous cycle, ignoring stall
    always_ff @(posedge Clk) begin
        if (Rst) begin
            byp_vld_p2  <= 1'b0;
            byp_reg_p2  <= 5'd0;
            byp_data_p2 <= 32'd0;
        end else if (wr_en) begin
            byp_vld_p2  <= 1'b1;
            byp_reg_p2  <= dst_p1;
            byp_data_p2 <= wr_data;
        end else begin
            byp_vld_p2  <= 1'b0;
        end
    end

    // Each valid entry retires exactly once, on its first cycle in WB
    always_ff @(posedge Clk) begin
        if (Rst) begin
            retire_cnt <= '0;
        end else if (vld_p1 && !done_p1) begin
            retire_cnt <= retire_cnt + RETIRE_W'(1);
        end
    end

    assign wb.WriteData_out   = wr_data;
    assign wb.WriteRegDst_out = {27'd0, dst_p1};
    assign wb.RegWrite_out    = wr_en;
    assign wb.BypassValid_out = byp_vld_p2;
    assign wb.BypassReg_out   = byp_reg_p2;
    assign wb.BypassData_out  = byp_data_p2;
    assign wb.RetireCount_out = retire_cnt;

endmodule
